dmem_responder: RTL and testbench

Data-memory responder for the five-stage MIPS core: the target end of the data-request interface driven by the execute stage. The execute stage emits an address, a 4-bit write strobe (0000 = load, nonzero = store) and store data. This block accepts one request at a time through a valid/ready handshake, performs the word access after a configurable wait, and returns read data or an error through a valid/ready response channel. It doubles as the data-RAM model for simulation and for FPGA bring-up.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_array.sv | 36 +++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_STRB_W = 4;

  localparam logic [DMEM_STRB_W-1:0] DMEM_STROBE_READ = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_STRB_W-1:0] strobe;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
  } dmem_resp_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the execute stage (master) and the
// data-memory responder (slave).
//   req_*  : valid/ready request channel (addr, byte strobe, store data)
//   resp_* : valid/ready response channel (load data, error)
interface dmem_if;
  import dmem_pkg::*;

  logic                   req_valid;
  logic [DMEM_ADDR_W-1:0] req_addr;
  logic [DMEM_STRB_W-1:0] req_strobe;
  logic [DMEM_DATA_W-1:0] req_wdata;
  logic                   req_ready;
  logic                   resp_valid;
  logic [DMEM_DATA_W-1:0] resp_rdata;
  logic                   resp_err;
  logic                   resp_ready;

  modport master (
    output req_valid, req_addr, req_strobe, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_strobe, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous byte-enabled write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   be    : per-byte write enables
//   addr  : word index
//   wdata : write data
//   rdata : combinational read of the addressed word
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DMEM_STRB_W-1:0] be,
  input  logic [DEPTH_LOG2-1:0]  addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; contents intentionally have no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(DMEM_STRB_W); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY
// cycles, performs the word access and holds the response until consumed.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : dmem_if slave (request and response channels)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic   clk,
  input  logic   resetn,
  dmem_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  dmem_state_t            state;
  logic [CNT_W-1:0]       cnt;
  dmem_req_t              req_q;
  dmem_resp_t             resp_q;
  logic                   resp_valid_q;
  logic                   ready_q;

  logic                   err_c;
  logic                   is_read_c;
  logic                   access_c;
  logic                   we_c;
  logic [DMEM_DATA_W-1:0] rdata_c;

  // Misaligned or beyond the array: rejected for loads and stores alike.
  assign err_c     = (req_q.addr[1:0] != 2'b00) ||
                     ((req_q.addr >> (DEPTH_LOG2 + 2)) != DMEM_ADDR_W'(0));
  assign is_read_c = (req_q.strobe == DMEM_STROBE_READ);
  assign access_c  = (state == BUSY) && (cnt == CNT_W'(0));
  assign we_c      = access_c && !err_c && !is_read_c;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .be    (req_q.strobe),
    .addr  (req_q.addr[DEPTH_LOG2+1:2]),
    .wdata (req_q.wdata),
    .rdata (rdata_c)
  );

  // Handshake FSM with latency counter, request latch and response registers.
  // ready_q is held low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      req_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (bus.req_valid && ready_q) begin
            req_q.addr   <= bus.req_addr;
            req_q.strobe <= bus.req_strobe;
            req_q.wdata  <= bus.req_wdata;
            cnt          <= CNT_W'(LATENCY - 1);
            ready_q      <= 1'b0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != CNT_W'(0)) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_q.err   <= err_c;
            resp_q.rdata <= (err_c || !is_read_c) ? DMEM_DATA_W'(0) : rdata_c;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          ready_q      <= 1'b0;
          resp_valid_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_q.rdata;
  assign bus.resp_err   = resp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_LOG2 = 10, LATENCY = 2).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned BOUND = 40;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_LOG2 (10),
    .LATENCY    (LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full transaction starting just after a negedge; returns response and
  // cycles from handshake to resp_valid.
  task automatic transact(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_strobe = strb;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < int'(BOUND)) begin
      @(negedge clk);
      n++;
    end
    if (n >= int'(BOUND)) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < int'(BOUND)) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] held_rd;
  logic        er;
  logic        held_er;
  int          lat;

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_strobe = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // 1. Full store then load
    transact(32'h100, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    check("st_full_latency", 32'(lat), 32'(LAT + 1));
    check("st_full_err", 32'(er), 32'd0);
    check("st_full_rdata", rd, 32'd0);
    check("ready_after_consume", 32'(bus.req_ready), 32'd1);
    transact(32'h100, 4'b0000, 32'h0, rd, er, lat);
    check("ld_full_rdata", rd, 32'hDEADBEEF);
    check("ld_full_err", 32'(er), 32'd0);
    check("ld_full_latency", 32'(lat), 32'(LAT + 1));

    // 2. Partial store
    transact(32'h100, 4'b0010, 32'h0000AA00, rd, er, lat);
    check("st_part_err", 32'(er), 32'd0);
    transact(32'h100, 4'b0000, 32'h0, rd, er, lat);
    check("ld_part_rdata", rd, 32'hDEADAAEF);

    // 3. Misaligned store
    transact(32'h102, 4'b1111, 32'h11223344, rd, er, lat);
    check("st_misal_err", 32'(er), 32'd1);
    check("st_misal_rdata", rd, 32'd0);
    transact(32'h100, 4'b0000, 32'h0, rd, er, lat);
    check("ld_after_misal", rd, 32'hDEADAAEF);

    // 4. Out-of-range load
    transact(32'h1000, 4'b0000, 32'h0, rd, er, lat);
    check("ld_oor_err", 32'(er), 32'd1);
    check("ld_oor_rdata", rd, 32'd0);

    // 5. Backpressure with a competing request held on the bus
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h100;
    bus.req_strobe = 4'b0000;
    @(negedge clk);
    bus.req_addr   = 32'h104;
    bus.req_strobe = 4'b1111;
    bus.req_wdata  = 32'h00000055;
    lat = 1;
    while (!bus.resp_valid && lat < int'(BOUND)) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(LAT + 1));
    held_rd = bus.resp_rdata;
    held_er = bus.resp_err;
    check("bp_first_rdata", held_rd, 32'hDEADAAEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 32'(bus.resp_valid), 32'd1);
      check("bp_rdata_held", bus.resp_rdata, held_rd);
      check("bp_err_held", 32'(bus.resp_err), 32'(held_er));
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp_ready_after_consume", 32'(bus.req_ready), 32'd1);
    check("bp_valid_dropped", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_second_accepted", 32'(bus.req_ready), 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < int'(BOUND)) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_latency", 32'(lat), 32'(LAT + 1));
    check("bp_second_err", 32'(bus.resp_err), 32'd0);
    check("bp_second_rdata", bus.resp_rdata, 32'd0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    transact(32'h104, 4'b0000, 32'h0, rd, er, lat);
    check("bp_second_stored", rd, 32'h00000055);

    // 6. Reset during the first BUSY cycle of a store
    transact(32'h200, 4'b1111, 32'h00000000, rd, er, lat);
    check("preload_err", 32'(er), 32'd0);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h200;
    bus.req_strobe = 4'b1111;
    bus.req_wdata  = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 resetn = 1'b0;
    #2;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    transact(32'h200, 4'b0000, 32'h0, rd, er, lat);
    check("midrst_store_dropped", rd, 32'h00000000);
    check("midrst_load_err", 32'(er), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
